keyboard_renderer: RTL and testbench

- Parametrised, pipelined renderer for a full strip of piano keys (N white keys plus pattern-correct black keys).
- Replaces per-key combinational sprites and adds press highlighting with a frame-based hold timer.
- Sits in the video path between the XVGA timing generator and the pixel mux.
- Emits one registered 24-bit pixel per vclock with fixed latency.

---
 rtl/piano_pkg.sv | 39 +++
 rtl/key_hold_timer.sv | 35 +++
 rtl/keyboard_renderer.sv | 194 +++++++++++++++++++
 tb/tb_keyboard_renderer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/piano_pkg.sv
// Shared note encoding, black-key pattern and colour defaults for the keyboard renderer.
package piano_pkg;

    typedef enum logic [2:0] {
        NoteC = 3'd0,
        NoteD = 3'd1,
        NoteE = 3'd2,
        NoteF = 3'd3,
        NoteG = 3'd4,
        NoteA = 3'd5,
        NoteB = 3'd6
    } note_e;

    // Bit n set when a black key follows the white key of note n (none after E or B).
    localparam logic [6:0] BLACK_AFTER = 7'b0111011;

    localparam logic [23:0] DefWhiteColor = 24'hFF_FF_FF;
    localparam logic [23:0] DefBlackColor = 24'h00_00_00;
    localparam logic [23:0] DefPressColor = 24'h00_80_FF;
    localparam logic [23:0] OutlineColor  = 24'h40_40_40;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

    function automatic logic [2:0] next_note(input logic [2:0] note);
        return (note == NoteB) ? NoteC : note + 3'd1;
    endfunction

    function automatic logic [2:0] prev_note(input logic [2:0] note);
        return (note == NoteC) ? NoteB : note - 3'd1;
    endfunction

endpackage

// File: rtl/key_hold_timer.sv
// Per-key highlight hold counter: reloads while pressed, counts down one step per frame.
module key_hold_timer
    import piano_pkg::*;
#(
    parameter int unsigned HOLD_FRAMES = 8
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic pressed_i,
    input  logic frame_tick_i,
    output logic active_o
);

    localparam int unsigned CntW = (clog2(HOLD_FRAMES + 1) > 0) ? clog2(HOLD_FRAMES + 1) : 1;
    localparam logic [CntW-1:0] HoldVal = CntW'(HOLD_FRAMES);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (pressed_i) begin
            cnt_d = HoldVal;
        end else if (frame_tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end

    assign active_o = (cnt_q != '0);

endmodule

// File: rtl/keyboard_renderer.sv
// Two-stage pipelined piano strip renderer with frame-snapshotted press highlighting.
// Optional white-key outline enabled by defining KEY_OUTLINE_EN.
module keyboard_renderer
    import piano_pkg::*;
#(
    parameter int unsigned NUM_WHITE        = 7,
    parameter int unsigned WHITE_KEY_WIDTH  = 90,
    parameter int unsigned BLACK_HALF_WIDTH = 15,
    parameter int unsigned HEIGHT           = 300,
    parameter int unsigned BLACK_KEY_HEIGHT = 180,
    parameter int unsigned START_NOTE       = 0,
    parameter int unsigned HOLD_FRAMES      = 8,
    parameter logic [23:0] WHITE_COLOR      = DefWhiteColor,
    parameter logic [23:0] BLACK_COLOR      = DefBlackColor,
    parameter logic [23:0] PRESS_COLOR      = DefPressColor
) (
    input  logic                 vclock,
    input  logic                 reset,
    input  logic [10:0]          x,
    input  logic [9:0]           y,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 frame_tick,
    input  logic [NUM_WHITE-1:0] white_pressed,
    input  logic [NUM_WHITE-2:0] black_pressed,
    output logic [23:0]          pixel,
    output logic                 in_key
);

    localparam int unsigned NumBlack      = NUM_WHITE - 1;
    localparam logic [5:0]  NumWhiteIdx   = 6'(NUM_WHITE);
    localparam logic [5:0]  NumBlackIdx   = 6'(NumBlack);
    localparam logic [10:0] OffLast       = 11'(WHITE_KEY_WIDTH - 1);
    localparam logic [10:0] BlackLeftOff  = 11'(WHITE_KEY_WIDTH - BLACK_HALF_WIDTH);
    localparam logic [10:0] BlackRightOff = 11'(BLACK_HALF_WIDTH);

    // Scan tracker: the _d values describe the pixel at the current hcount.
    logic        trk_q, trk_d;
    logic [5:0]  idx_q, idx_d;
    logic [10:0] off_q, off_d;
    logic [2:0]  note_q, note_d;

    always_comb begin
        trk_d  = trk_q;
        idx_d  = idx_q;
        off_d  = off_q;
        note_d = note_q;
        if (hcount == x) begin
            trk_d  = 1'b1;
            idx_d  = '0;
            off_d  = '0;
            note_d = 3'(START_NOTE);
        end else if (idx_q < NumWhiteIdx) begin
            if (off_q == OffLast) begin
                off_d  = '0;
                idx_d  = idx_q + 6'd1;
                note_d = next_note(note_q);
            end else begin
                off_d = off_q + 11'd1;
            end
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            trk_q  <= 1'b0;
            idx_q  <= '0;
            off_q  <= '0;
            note_q <= '0;
        end else begin
            trk_q  <= trk_d;
            idx_q  <= idx_d;
            off_q  <= off_d;
            note_q <= note_d;
        end
    end

    // Stage 1 hit detection
    logic [10:0] v_ext, y_top, y_end, y_black_end;
    logic        in_x, white_hit, left_black, right_black, black_hit;
    logic [5:0]  bidx;

    always_comb begin
        v_ext       = {1'b0, vcount};
        y_top       = {1'b0, y};
        y_end       = y_top + 11'(HEIGHT);
        y_black_end = y_top + 11'(BLACK_KEY_HEIGHT);
        // hcount[10] set means past the 1024-pixel line; never wrap back in.
        in_x        = trk_d && (hcount >= x) && !hcount[10];
        white_hit   = in_x && (idx_d < NumWhiteIdx) && (v_ext >= y_top) && (v_ext < y_end);
        left_black  = (off_d >= BlackLeftOff) && (idx_d < NumBlackIdx) && BLACK_AFTER[note_d];
        right_black = (off_d < BlackRightOff) && (idx_d != '0)
                      && BLACK_AFTER[prev_note(note_d)];
        black_hit   = white_hit && (v_ext < y_black_end) && (left_black || right_black);
        bidx        = left_black ? idx_d : idx_d - 6'd1;
    end

    logic       s1_white_q, s1_black_q;
    logic [5:0] s1_widx_q, s1_bidx_q;
`ifdef KEY_OUTLINE_EN
    logic       s1_outline_q;
`endif

    always_ff @(posedge vclock) begin
        if (reset) begin
            s1_white_q   <= 1'b0;
            s1_black_q   <= 1'b0;
            s1_widx_q    <= '0;
            s1_bidx_q    <= '0;
`ifdef KEY_OUTLINE_EN
            s1_outline_q <= 1'b0;
`endif
        end else begin
            s1_white_q   <= white_hit;
            s1_black_q   <= black_hit;
            s1_widx_q    <= idx_d;
            s1_bidx_q    <= bidx;
`ifdef KEY_OUTLINE_EN
            s1_outline_q <= (off_d == '0) || (v_ext == y_end - 11'd1);
`endif
        end
    end

    // Hold timers and the frame-aligned highlight snapshot
    logic [NUM_WHITE-1:0] white_act, white_snap_q;
    logic [NumBlack-1:0]  black_act, black_snap_q;

    for (genvar i = 0; i < NUM_WHITE; i++) begin : g_white
        key_hold_timer #(
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_timer (
            .clk_i        (vclock),
            .reset_i      (reset),
            .pressed_i    (white_pressed[i]),
            .frame_tick_i (frame_tick),
            .active_o     (white_act[i])
        );
    end

    for (genvar i = 0; i < NumBlack; i++) begin : g_black
        key_hold_timer #(
            .HOLD_FRAMES (HOLD_FRAMES)
        ) u_timer (
            .clk_i        (vclock),
            .reset_i      (reset),
            .pressed_i    (black_pressed[i]),
            .frame_tick_i (frame_tick),
            .active_o     (black_act[i])
        );
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            white_snap_q <= '0;
            black_snap_q <= '0;
        end else if (frame_tick) begin
            white_snap_q <= white_act;
            black_snap_q <= black_act;
        end
    end

    // Stage 2 colour selection
    logic [63:0] white_snap_ext, black_snap_ext;
    logic [23:0] pixel_d;
    logic        in_key_d;

    always_comb begin
        white_snap_ext = 64'(white_snap_q);
        black_snap_ext = 64'(black_snap_q);
        pixel_d        = '0;
        in_key_d       = s1_white_q || s1_black_q;
        if (s1_black_q) begin
            pixel_d = black_snap_ext[s1_bidx_q] ? PRESS_COLOR : BLACK_COLOR;
        end else if (s1_white_q) begin
`ifdef KEY_OUTLINE_EN
            if (s1_outline_q) pixel_d = OutlineColor;
            else pixel_d = white_snap_ext[s1_widx_q] ? PRESS_COLOR : WHITE_COLOR;
`else
            pixel_d = white_snap_ext[s1_widx_q] ? PRESS_COLOR : WHITE_COLOR;
`endif
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            pixel  <= '0;
            in_key <= 1'b0;
        end else begin
            pixel  <= pixel_d;
            in_key <= in_key_d;
        end
    end

endmodule

// File: tb/tb_keyboard_renderer.sv
// Self-checking bench: randomized scan lines, presses, ticks and resets against a geometric model.
module tb_keyboard_renderer;

    localparam int W       = 90;
    localparam int BHW     = 15;
    localparam int HT      = 300;
    localparam int BKH     = 180;
    localparam int HOLD    = 8;
    localparam int LINE    = 1040;
    localparam int IDLE_H  = 1100;
    localparam logic [23:0] C_WHITE   = 24'hFF_FF_FF;
    localparam logic [23:0] C_BLACK   = 24'h00_00_00;
    localparam logic [23:0] C_PRESS   = 24'h00_80_FF;
    localparam logic [23:0] C_OUTLINE = 24'h40_40_40;

    logic        vclock = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] x = 11'd100;
    logic [9:0]  y = 10'd50;
    logic [10:0] hcount = 11'd1100;
    logic [9:0]  vcount = '0;
    logic        frame_tick = 1'b0;
    logic [6:0]  white_pressed = '0;
    logic [5:0]  black_pressed = '0;
    logic [23:0] pixel, pixel_e;
    logic        in_key, in_key_e;

    always #5 vclock = ~vclock;

    keyboard_renderer u_dut (
        .vclock        (vclock),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .hcount        (hcount),
        .vcount        (vcount),
        .frame_tick    (frame_tick),
        .white_pressed (white_pressed),
        .black_pressed (black_pressed),
        .pixel         (pixel),
        .in_key        (in_key)
    );

    keyboard_renderer #(
        .NUM_WHITE  (3),
        .START_NOTE (2)
    ) u_dut_e (
        .vclock        (vclock),
        .reset         (reset),
        .x             (x),
        .y             (y),
        .hcount        (hcount),
        .vcount        (vcount),
        .frame_tick    (frame_tick),
        .white_pressed (white_pressed[2:0]),
        .black_pressed (black_pressed[1:0]),
        .pixel         (pixel_e),
        .in_key        (in_key_e)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        int kind;   // 0 none, 1 white, 2 black
        int idx;
        bit outline;
    } geom_t;

    // Reference model state
    int    tmr_w[7];
    int    tmr_b[6];
    bit    snap_w[7];
    bit    snap_b[6];
    bit    trk = 0;
    bit    p_rst = 1, p_ft = 0, p_trk = 0;
    logic [6:0] p_wp = '0;
    logic [5:0] p_bp = '0;
    geom_t e1[2];
    bit    e1_valid = 0;
    int    e1_h = 0, e2_h = 0;
    logic [23:0] e2_pix[2];
    bit    e2_key[2];
    bit    e2_valid = 0;

    // Stimulus applied at the next drive point
    bit          nxt_rst = 1, nxt_ft = 0;
    logic [6:0]  nxt_wp = '0;
    logic [5:0]  nxt_bp = '0;
    logic [10:0] nxt_x = 11'd100;
    logic [9:0]  nxt_y = 10'd50;

    function automatic bit has_black(input int note);
        return (note != 2) && (note != 6);
    endfunction

    function automatic geom_t geom(input int h, input int v, input int xs, input int ys,
                                   input int nw, input int start, input bit tr);
        geom_t g;
        int rel, k, off;
        g.kind = 0;
        g.idx = 0;
        g.outline = 0;
        if (!tr || h < xs || h >= 1024 || v < ys || v >= ys + HT) return g;
        rel = h - xs;
        k = rel / W;
        off = rel % W;
        if (k >= nw) return g;
        g.kind = 1;
        g.idx = k;
        g.outline = (off == 0) || (v == ys + HT - 1);
        if (v < ys + BKH) begin
            if (off >= W - BHW && k < nw - 1 && has_black((start + k) % 7)) begin
                g.kind = 2;
                g.idx = k;
            end else if (off < BHW && k > 0 && has_black((start + k - 1) % 7)) begin
                g.kind = 2;
                g.idx = k - 1;
            end
        end
        return g;
    endfunction

    function automatic logic [23:0] color(input geom_t g);
        if (g.kind == 2) return snap_b[g.idx] ? C_PRESS : C_BLACK;
        if (g.kind == 1) begin
`ifdef KEY_OUTLINE_EN
            if (g.outline) return C_OUTLINE;
`endif
            return snap_w[g.idx] ? C_PRESS : C_WHITE;
        end
        return 24'h0;
    endfunction

    task automatic step(input int h, input int v);
        bit cur_trk;
        @(posedge vclock);
        #1;
        if (p_rst) begin
            trk = 0;
            for (int i = 0; i < 7; i++) begin tmr_w[i] = 0; snap_w[i] = 0; end
            for (int i = 0; i < 6; i++) begin tmr_b[i] = 0; snap_b[i] = 0; end
        end else begin
            trk = p_trk;
            if (p_ft) begin
                for (int i = 0; i < 7; i++) snap_w[i] = (tmr_w[i] != 0);
                for (int i = 0; i < 6; i++) snap_b[i] = (tmr_b[i] != 0);
            end
            for (int i = 0; i < 7; i++)
                if (p_wp[i]) tmr_w[i] = HOLD;
                else if (p_ft && tmr_w[i] > 0) tmr_w[i]--;
            for (int i = 0; i < 6; i++)
                if (p_bp[i]) tmr_b[i] = HOLD;
                else if (p_ft && tmr_b[i] > 0) tmr_b[i]--;
        end
        if (p_rst) begin
            for (int d = 0; d < 2; d++) begin
                e2_pix[d] = '0;
                e2_key[d] = 0;
                e1[d].kind = 0;
            end
            e2_valid = 1;
            e1_valid = 1;
        end
        if (e2_valid) begin
            check_eq($sformatf("pixel h=%0d", e2_h), 32'(pixel), 32'(e2_pix[0]));
            check_eq($sformatf("in_key h=%0d", e2_h), 32'(in_key), 32'(e2_key[0]));
            check_eq($sformatf("pixel_e h=%0d", e2_h), 32'(pixel_e), 32'(e2_pix[1]));
            check_eq($sformatf("in_key_e h=%0d", e2_h), 32'(in_key_e), 32'(e2_key[1]));
        end
        for (int d = 0; d < 2; d++) begin
            e2_pix[d] = color(e1[d]);
            e2_key[d] = (e1[d].kind != 0);
        end
        e2_valid = e1_valid;
        e2_h = e1_h;

        reset = nxt_rst;
        frame_tick = nxt_ft;
        white_pressed = nxt_wp;
        black_pressed = nxt_bp;
        x = nxt_x;
        y = nxt_y;
        hcount = 11'(h);
        vcount = 10'(v);
        cur_trk = trk || (h == int'(nxt_x));
        e1[0] = geom(h, v, int'(nxt_x), int'(nxt_y), 7, 0, cur_trk);
        e1[1] = geom(h, v, int'(nxt_x), int'(nxt_y), 3, 2, cur_trk);
        e1_valid = 1;
        e1_h = h;
        p_rst = nxt_rst;
        p_ft = nxt_ft;
        p_wp = nxt_wp;
        p_bp = nxt_bp;
        p_trk = cur_trk;
    endtask

    task automatic run_line(input int v, input int rst_at, input int tick_at);
        for (int h = 0; h < LINE; h++) begin
            nxt_rst = (h == rst_at);
            nxt_ft = (h == tick_at);
            step(h, v);
        end
        nxt_rst = 0;
        nxt_ft = 0;
    endtask

    task automatic tick();
        nxt_ft = 1;
        step(IDLE_H, 0);
        nxt_ft = 0;
    endtask

    initial begin
        for (int i = 0; i < 7; i++) begin tmr_w[i] = 0; snap_w[i] = 0; end
        for (int i = 0; i < 6; i++) begin tmr_b[i] = 0; snap_b[i] = 0; end
        for (int d = 0; d < 2; d++) begin e1[d].kind = 0; e1[d].idx = 0; e1[d].outline = 0; end

        repeat (3) step(IDLE_H, 0);
        nxt_rst = 0;
        step(IDLE_H, 0);

        // Default strip at x=100,y=50: black band, white band, then reset at hcount=300
        run_line(60, -1, -1);
        run_line(250, -1, -1);
        run_line(60, 300, -1);
        run_line(60, -1, -1);

        // White key 2 held for one frame, then released and held through the hold window
        nxt_wp = 7'b0000100;
        tick();
        run_line(250, -1, -1);
        nxt_wp = '0;
        for (int f = 0; f < 11; f++) begin
            tick();
            run_line(250, -1, -1);
        end

        // Black key 0 pressed on the same cycle as frame_tick
        nxt_bp = 6'b000001;
        tick();
        nxt_bp = '0;
        run_line(60, -1, -1);
        tick();
        run_line(60, -1, -1);

        // Randomized placement, presses, mid-line ticks and resets
        for (int n = 0; n < 20; n++) begin
            int v, rst_at, tick_at;
            nxt_x = 11'($urandom_range(0, 400));
            nxt_y = 10'($urandom_range(0, 600));
            v = int'(nxt_y) + $urandom_range(0, 310) - 5;
            if (v < 0) v = 0;
            nxt_wp = 7'($urandom);
            nxt_bp = 6'($urandom);
            rst_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, LINE - 1) : -1;
            tick_at = ($urandom_range(0, 1) == 0) ? $urandom_range(0, LINE - 1) : -1;
            if ($urandom_range(0, 1) == 0) tick();
            run_line(v, rst_at, tick_at);
            if ($urandom_range(0, 2) == 0) nxt_wp = '0;
            nxt_bp = '0;
        end

        repeat (3) step(IDLE_H, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
